// File: rtl/slave_internal_error_rd_resp_gen.sv
// Internal error read-response source: queues AR requests rejected inside the slave and
// plays each back as a full ARLEN+1 beat error burst. Optional fill pattern: SLAVE_ERR_RD_DATA_PATTERN_EN.
module slave_internal_error_rd_resp_gen #(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         err_req_valid,
  output logic                         err_req_ready,
  input  logic [ID_WIDTH-1:0]          err_req_id,
  input  logic [7:0]                   err_req_len,
  input  logic [1:0]                   err_req_resp,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [ID_WIDTH-1:0]          RID,
  output logic [1:0]                   RRESP,
  output logic [DATA_WIDTH-1:0]        RDATA,
  output logic                         RLAST,
  output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          len;
    logic [1:0]          resp;
  } req_t;

  req_t          fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  req_t          burst;
  logic [7:0]    beat_cnt;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic last_beat;
  req_t push_entry;

  // OKAY/EXOKAY are meaningless for a rejected request, so anything without bit 1 becomes SLVERR
  assign push_entry    = '{id: err_req_id, len: err_req_len,
                           resp: (err_req_resp[1] ? err_req_resp : 2'b10)};
  assign err_req_ready = (pending_cnt != CW'(DEPTH));
  assign push          = err_req_valid && err_req_ready;
  assign fifo_nonempty = (pending_cnt != '0);
  assign last_beat     = (beat_cnt == burst.len);
  assign pop           = fifo_nonempty &&
                         ((state == IDLE) || (RREADY && last_beat));

  assign RVALID = (state == SEND);
  assign RID    = burst.id;
  assign RRESP  = burst.resp;
  assign RLAST  = RVALID && last_beat;

`ifdef SLAVE_ERR_RD_DATA_PATTERN_EN
  assign RDATA = RVALID ? {(DATA_WIDTH/32){32'hDEADBEEF}} : '0;
`else
  assign RDATA = '0;
`endif

  // A pop on the final handshake reloads the burst registers so the next burst follows with no bubble
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending_cnt <= '0;
      burst       <= '0;
      beat_cnt    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   pending_cnt <= pending_cnt + CW'(1);
        2'b01:   pending_cnt <= pending_cnt - CW'(1);
        default: pending_cnt <= pending_cnt;
      endcase
      case (state)
        IDLE: begin
          if (pop) begin
            burst    <= fifo_mem[rd_ptr];
            beat_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (RREADY) begin
            if (!last_beat) begin
              beat_cnt <= beat_cnt + 8'd1;
            end else if (pop) begin
              burst    <= fifo_mem[rd_ptr];
              beat_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_internal_error_rd_resp_gen.sv
// Directed self-checking bench for slave_internal_error_rd_resp_gen (DEPTH=4, DATA_WIDTH=64).
module tb_slave_internal_error_rd_resp_gen;

  logic        ACLK;
  logic        ARESETn;
  logic        err_req_valid;
  logic        err_req_ready;
  logic [7:0]  err_req_id;
  logic [7:0]  err_req_len;
  logic [1:0]  err_req_resp;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  RID;
  logic [1:0]  RRESP;
  logic [63:0] RDATA;
  logic        RLAST;
  logic [2:0]  pending_cnt;

  int n_checks;
  int n_fail;

`ifdef SLAVE_ERR_RD_DATA_PATTERN_EN
  localparam logic [63:0] BEAT_DATA = 64'hDEADBEEFDEADBEEF;
`else
  localparam logic [63:0] BEAT_DATA = 64'h0;
`endif

  slave_internal_error_rd_resp_gen #(.ID_WIDTH(8), .DATA_WIDTH(64), .DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .err_req_valid(err_req_valid), .err_req_ready(err_req_ready),
    .err_req_id(err_req_id), .err_req_len(err_req_len), .err_req_resp(err_req_resp),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RRESP(RRESP),
    .RDATA(RDATA), .RLAST(RLAST), .pending_cnt(pending_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Inputs are driven and outputs sampled on the falling edge
  task automatic applyStimulus(input logic v, input logic [7:0] id, input logic [7:0] len,
                               input logic [1:0] resp);
    err_req_valid = v;
    err_req_id    = id;
    err_req_len   = len;
    err_req_resp  = resp;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    RREADY  = 1'b0;
    applyStimulus(1'b0, 8'h0, 8'h0, 2'b00);
    repeat (3) @(negedge ACLK);
    n_checks++; if (err_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", err_req_ready); end
    n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b expected 0", RVALID); end
    n_checks++; if (RID !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_rid: got %h expected 00", RID); end
    n_checks++; if (RRESP !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rresp: got %b expected 00", RRESP); end
    n_checks++; if (RDATA !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", RDATA); end
    n_checks++; if (RLAST !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rlast: got %b expected 0", RLAST); end
    n_checks++; if (pending_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_pending: got %0d expected 0", pending_cnt); end
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic test_single_beat();
    RREADY = 1'b1;
    applyStimulus(1'b1, 8'h03, 8'd0, 2'b11);
    @(negedge ACLK);
    applyStimulus(1'b0, 8'h0, 8'h0, 2'b00);
    n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL single_c1_rvalid: got %b expected 0", RVALID); end
    n_checks++; if (pending_cnt !== 3'd1) begin n_fail++; $display("[TB] FAIL single_c1_pending: got %0d expected 1", pending_cnt); end
    @(negedge ACLK);
    n_checks++; if (RVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rvalid: got %b expected 1", RVALID); end
    n_checks++; if (RID !== 8'h03) begin n_fail++; $display("[TB] FAIL single_rid: got %h expected 03", RID); end
    n_checks++; if (RRESP !== 2'b11) begin n_fail++; $display("[TB] FAIL single_rresp: got %b expected 11", RRESP); end
    n_checks++; if (RLAST !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rlast: got %b expected 1", RLAST); end
    n_checks++; if (RDATA !== BEAT_DATA) begin n_fail++; $display("[TB] FAIL single_rdata: got %h expected %h", RDATA, BEAT_DATA); end
    @(negedge ACLK);
    n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL single_after_rvalid: got %b expected 0", RVALID); end
    n_checks++; if (pending_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL single_after_pending: got %0d expected 0", pending_cnt); end
    n_checks++; if (RDATA !== 64'h0) begin n_fail++; $display("[TB] FAIL single_after_rdata: got %h expected 0", RDATA); end
    RREADY = 1'b0;
  endtask

  task automatic test_rready_toggle();
    int beats;
    logic rr, seen, prev_stall, plast;
    logic [7:0] pid;
    logic [1:0] presp;
    logic [63:0] pdata;
    beats = 0; rr = 1'b0; seen = 1'b0; prev_stall = 1'b0;
    pid = '0; presp = '0; plast = 1'b0; pdata = '0;
    RREADY = 1'b0;
    applyStimulus(1'b1, 8'h05, 8'd3, 2'b10);
    @(negedge ACLK);
    applyStimulus(1'b0, 8'h0, 8'h0, 2'b00);
    for (int cyc = 0; cyc < 40 && beats < 4; cyc++) begin
      @(negedge ACLK);
      if (prev_stall) begin
        n_checks++; if (RVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_rvalid: got %b expected 1", RVALID); end
        n_checks++; if ({RID, RRESP, RLAST, RDATA} !== {pid, presp, plast, pdata})
          begin n_fail++; $display("[TB] FAIL stall_hold: got %h/%b/%b expected %h/%b/%b", RID, RRESP, RLAST, pid, presp, plast); end
      end
      if (RVALID) begin
        seen = 1'b1;
        n_checks++; if (RID !== 8'h05) begin n_fail++; $display("[TB] FAIL toggle_rid: got %h expected 05", RID); end
        n_checks++; if (RRESP !== 2'b10) begin n_fail++; $display("[TB] FAIL toggle_rresp: got %b expected 10", RRESP); end
        n_checks++; if (RLAST !== (beats == 3)) begin n_fail++; $display("[TB] FAIL toggle_rlast: got %b expected %b at beat %0d", RLAST, (beats == 3), beats); end
        n_checks++; if (RDATA !== BEAT_DATA) begin n_fail++; $display("[TB] FAIL toggle_rdata: got %h expected %h", RDATA, BEAT_DATA); end
      end
      rr = seen ? ~rr : 1'b0;
      RREADY = rr;
      if (RVALID && rr) beats++;
      prev_stall = RVALID && !rr;
      pid = RID; presp = RRESP; plast = RLAST; pdata = RDATA;
    end
    n_checks++; if (beats !== 4) begin n_fail++; $display("[TB] FAIL toggle_beats: got %0d expected 4", beats); end
    @(negedge ACLK);
    RREADY = 1'b0;
    n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL toggle_end_rvalid: got %b expected 0", RVALID); end
  endtask

  task automatic test_back_to_back();
    int lens [5];
    logic [1:0] resps [5];
    logic [7:0] exp_id [$];
    logic [1:0] exp_resp [$];
    logic       exp_last [$];
    int total;
    lens  = '{1, 0, 2, 0, 1};
    resps = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    for (int r = 0; r < 5; r++)
      for (int b = 0; b <= lens[r]; b++) begin
        exp_id.push_back(8'h10 + 8'(r));
        exp_resp.push_back(resps[r]);
        exp_last.push_back(b == lens[r]);
      end
    total = exp_id.size();
    RREADY = 1'b0;
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b1, 8'h10 + 8'(r), 8'(lens[r]), resps[r]);
      @(negedge ACLK);
    end
    applyStimulus(1'b1, 8'h99, 8'd0, 2'b11);
    n_checks++; if (pending_cnt !== 3'd4) begin n_fail++; $display("[TB] FAIL b2b_pending_full: got %0d expected 4", pending_cnt); end
    n_checks++; if (err_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ready_full: got %b expected 0", err_req_ready); end
    n_checks++; if (RVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_loaded: got %b expected 1", RVALID); end
    @(negedge ACLK);
    applyStimulus(1'b0, 8'h0, 8'h0, 2'b00);
    n_checks++; if (pending_cnt !== 3'd4) begin n_fail++; $display("[TB] FAIL b2b_refused: got %0d expected 4", pending_cnt); end
    RREADY = 1'b1;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge ACLK);
      n_checks++; if ({RVALID, RID, RRESP, RLAST} !== {1'b1, exp_id[k], exp_resp[k], exp_last[k]})
        begin n_fail++; $display("[TB] FAIL b2b_beat%0d: got v=%b id=%h resp=%b last=%b expected v=1 id=%h resp=%b last=%b",
                                 k, RVALID, RID, RRESP, RLAST, exp_id[k], exp_resp[k], exp_last[k]); end
    end
    @(negedge ACLK);
    RREADY = 1'b0;
    n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_end_rvalid: got %b expected 0", RVALID); end
    n_checks++; if (pending_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL b2b_end_pending: got %0d expected 0", pending_cnt); end
  endtask

  task automatic test_resp_map();
    int got;
    got = 0;
    RREADY = 1'b1;
    applyStimulus(1'b1, 8'h07, 8'd0, 2'b01);
    @(negedge ACLK);
    applyStimulus(1'b1, 8'h08, 8'd0, 2'b00);
    @(negedge ACLK);
    applyStimulus(1'b0, 8'h0, 8'h0, 2'b00);
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      if (RVALID) begin
        n_checks++; if ({RID, RRESP} !== {(got == 0) ? 8'h07 : 8'h08, 2'b10})
          begin n_fail++; $display("[TB] FAIL resp_map%0d: got id=%h resp=%b expected id=%h resp=10", got, RID, RRESP, (got == 0) ? 8'h07 : 8'h08); end
        got++;
      end
      @(negedge ACLK);
    end
    n_checks++; if (got !== 2) begin n_fail++; $display("[TB] FAIL resp_map_count: got %0d expected 2", got); end
    RREADY = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int stray;
    stray = 0;
    RREADY = 1'b0;
    applyStimulus(1'b1, 8'h20, 8'd7, 2'b11);
    @(negedge ACLK);
    applyStimulus(1'b1, 8'h21, 8'd0, 2'b10);
    @(negedge ACLK);
    applyStimulus(1'b1, 8'h22, 8'd0, 2'b10);
    @(negedge ACLK);
    applyStimulus(1'b0, 8'h0, 8'h0, 2'b00);
    n_checks++; if ({RVALID, pending_cnt} !== {1'b1, 3'd2}) begin n_fail++; $display("[TB] FAIL rst_setup: got v=%b cnt=%0d expected v=1 cnt=2", RVALID, pending_cnt); end
    RREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rvalid: got %b expected 0", RVALID); end
    n_checks++; if (pending_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_pending: got %0d expected 0", pending_cnt); end
    n_checks++; if (err_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_ready: got %b expected 1", err_req_ready); end
    n_checks++; if (RLAST !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rlast: got %b expected 0", RLAST); end
    ARESETn = 1'b1;
    repeat (12) begin
      @(negedge ACLK);
      if (RVALID) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("[TB] FAIL rst_no_beats: got %0d valid cycles expected 0", stray); end
    RREADY = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_beat();
    test_rready_toggle();
    test_back_to_back();
    test_resp_map();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
